// File: rtl/pe_disp_pkg.sv
// Shared definitions for the PE array dispatcher.
// Contents:
//   - host command opcodes (anything above OP_WAIT_IDLE is treated as a NOP)
//   - dispatcher FSM state encodings, kept as plain localparams so older
//     tools and existing waveform decoders can keep using the raw values
//   - tile-config word count and field width, and the data word width
package pe_disp_pkg;

    localparam logic [2:0] OP_CFG       = 3'd0;
    localparam logic [2:0] OP_LOAD_W    = 3'd1;
    localparam logic [2:0] OP_LOAD_I    = 3'd2;
    localparam logic [2:0] OP_STORE     = 3'd3;
    localparam logic [2:0] OP_WAIT_IDLE = 3'd4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CFG_RD  = 3'd1;
    localparam logic [2:0] S_CFG_WR  = 3'd2;
    localparam logic [2:0] S_LD_CMD  = 3'd3;
    localparam logic [2:0] S_LD_DATA = 3'd4;
    localparam logic [2:0] S_ST_CMD  = 3'd5;
    localparam logic [2:0] S_ST_DATA = 3'd6;
    localparam logic [2:0] S_WAIT    = 3'd7;

    localparam int CFG_WORDS   = 8;
    localparam int CFG_FIELD_W = 13;
    localparam int DATA_W      = 16;

    // NOP opcodes never address a PE, so they can never raise err.
    function automatic logic is_real_op(input logic [2:0] op);
        return op <= OP_WAIT_IDLE;
    endfunction

endpackage

// File: rtl/pe_array_dispatcher_pe_dout_mux.sv
// NPE-way select of the per-PE dout stream by PE id.
// Ports:
//   sel        PE id to select; ids >= NPE select nothing (valid 0, data 0)
//   valid_in   per-PE dout_valid
//   data_in    per-PE dout_data, PE k at bits [16k+15:16k]
//   valid_out  selected dout_valid
//   data_out   selected dout_data
module pe_dout_mux
    import pe_disp_pkg::*;
#(
    parameter int NPE = 16
) (
    input  logic [7:0]            sel,
    input  logic [NPE-1:0]        valid_in,
    input  logic [DATA_W*NPE-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_W-1:0]     data_out
);

    // Compare against every PE index so that out-of-range ids fall through
    // to the zero default instead of indexing past the bus.
    always_comb begin
        valid_out = 1'b0;
        data_out  = '0;
        for (int k = 0; k < NPE; k++) begin
            if (int'(sel) == k) begin
                valid_out = valid_in[k];
                data_out  = data_in[DATA_W*k +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pe_array_dispatcher.sv
// Host-side master for the per-PE command/data interface of the core array.
// Pops host commands, drives the PE id/broadcast/cfg bus, load/store strobes
// and the din stream, and returns the addressed PE's dout stream to the host.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_*                     host command stream (accepted only in S_IDLE)
//   src_*                     host data into the PEs (CFG words, LOAD data)
//   snk_*                     PE output data back to the host (STORE)
//   id, broadcast             latched target of the last accepted command
//   cfg, cfg_Iext..cfg_Wori   one-cycle config strobe and 13-bit tile config
//   din_valid, din_data       data stream to the PEs, no backpressure
//   load_weight, load_input,
//   store_output              one-cycle registered command strobes
//   pe_dout_valid/data        per-PE output streams
//   dout_ready                ready back to the PEs during STORE
//   pe_idle                   per-PE idle flags
//   err                       sticky out-of-range id flag
module pe_array_dispatcher
    import pe_disp_pkg::*;
#(
    parameter int NPE  = 16,
    parameter int LENW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [7:0]             cmd_id,
    input  logic                   cmd_bcast,
    input  logic [LENW-1:0]        cmd_len,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [DATA_W-1:0]      src_data,
    output logic                   snk_valid,
    input  logic                   snk_ready,
    output logic [DATA_W-1:0]      snk_data,
    output logic [7:0]             id,
    output logic                   broadcast,
    output logic                   cfg,
    output logic [CFG_FIELD_W-1:0] cfg_Iext,
    output logic [CFG_FIELD_W-1:0] cfg_Oext,
    output logic [CFG_FIELD_W-1:0] cfg_Hext,
    output logic [CFG_FIELD_W-1:0] cfg_Wext,
    output logic [CFG_FIELD_W-1:0] cfg_Iori,
    output logic [CFG_FIELD_W-1:0] cfg_Oori,
    output logic [CFG_FIELD_W-1:0] cfg_Hori,
    output logic [CFG_FIELD_W-1:0] cfg_Wori,
    output logic                   din_valid,
    output logic [DATA_W-1:0]      din_data,
    output logic                   load_weight,
    output logic                   load_input,
    output logic                   store_output,
    input  logic [NPE-1:0]         pe_dout_valid,
    input  logic [DATA_W*NPE-1:0]  pe_dout_data,
    output logic                   dout_ready,
    input  logic [NPE-1:0]         pe_idle,
    output logic                   err
);

    logic [2:0]             state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [7:0]             id_q, id_d;
    logic                   bcast_q, bcast_d;
    logic [LENW-1:0]        len_q, len_d;
    logic [LENW-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   cfg_q, cfg_d;
    logic                   ld_w_q, ld_w_d;
    logic                   ld_i_q, ld_i_d;
    logic                   st_q, st_d;
    logic [CFG_FIELD_W-1:0] cfg_reg_q [CFG_WORDS];
    logic [CFG_FIELD_W-1:0] cfg_reg_d [CFG_WORDS];

    logic                   sel_valid;
    logic [DATA_W-1:0]      sel_data;
    logic                   target_idle;
    logic                   last_word;

    pe_dout_mux #(.NPE(NPE)) u_dout_mux (
        .sel       (id_q),
        .valid_in  (pe_dout_valid),
        .data_in   (pe_dout_data),
        .valid_out (sel_valid),
        .data_out  (sel_data)
    );

    // WAIT_IDLE target: all PEs when broadcasting, otherwise the addressed
    // PE only. An out-of-range unicast id never reaches S_WAIT.
    always_comb begin
        target_idle = 1'b0;
        if (bcast_q) begin
            target_idle = &pe_idle;
        end else begin
            for (int k = 0; k < NPE; k++) begin
                if (int'(id_q) == k) target_idle = pe_idle[k];
            end
        end
    end

    // Word counter runs 0..len-1, so len=2^LENW-1 finishes without wrapping.
    assign last_word = (cnt_q == len_q - LENW'(1));

    // Next-state, stream handshakes and strobe generation. Strobes are
    // derived from the next state so each one is a registered pulse aligned
    // with the state that owns it.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        id_d       = id_q;
        bcast_d    = bcast_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        cfg_reg_d  = cfg_reg_q;
        cmd_ready  = (state_q == S_IDLE);
        src_ready  = 1'b0;
        din_valid  = 1'b0;
        din_data   = '0;
        snk_valid  = 1'b0;
        snk_data   = '0;
        dout_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    id_d    = cmd_id;
                    bcast_d = (cmd_op == OP_STORE) ? 1'b0 : cmd_bcast;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    if (is_real_op(cmd_op) && !bcast_d && int'(cmd_id) >= NPE) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_CFG:                state_d = S_CFG_RD;
                            OP_LOAD_W, OP_LOAD_I:  state_d = S_LD_CMD;
                            OP_STORE:              state_d = S_ST_CMD;
                            OP_WAIT_IDLE:          state_d = S_WAIT;
                            default:               state_d = S_IDLE;
                        endcase
                    end
                end
            end
            S_CFG_RD: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    cfg_reg_d[cnt_q[2:0]] = src_data[CFG_FIELD_W-1:0];
                    if (cnt_q == LENW'(CFG_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CFG_WR;
                    end else begin
                        cnt_d = cnt_q + LENW'(1);
                    end
                end
            end
            S_CFG_WR: state_d = S_IDLE;
            S_LD_CMD: state_d = (len_q == '0) ? S_IDLE : S_LD_DATA;
            S_LD_DATA: begin
                src_ready = 1'b1;
                din_valid = src_valid;
                din_data  = src_data;
                if (src_valid) begin
                    if (last_word) state_d = S_IDLE;
                    else           cnt_d   = cnt_q + LENW'(1);
                end
            end
            S_ST_CMD: state_d = (len_q == '0) ? S_IDLE : S_ST_DATA;
            S_ST_DATA: begin
                snk_valid  = sel_valid;
                snk_data   = sel_data;
                dout_ready = snk_ready;
                if (sel_valid && snk_ready) begin
                    if (last_word) state_d = S_IDLE;
                    else           cnt_d   = cnt_q + LENW'(1);
                end
            end
            S_WAIT: if (target_idle) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cfg_d  = (state_d == S_CFG_WR);
        ld_w_d = (state_d == S_LD_CMD) && (op_d == OP_LOAD_W);
        ld_i_d = (state_d == S_LD_CMD) && (op_d == OP_LOAD_I);
        st_d   = (state_d == S_ST_CMD);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            id_q    <= '0;
            bcast_q <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cfg_q   <= 1'b0;
            ld_w_q  <= 1'b0;
            ld_i_q  <= 1'b0;
            st_q    <= 1'b0;
            for (int i = 0; i < CFG_WORDS; i++) cfg_reg_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            id_q      <= id_d;
            bcast_q   <= bcast_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            cfg_q     <= cfg_d;
            ld_w_q    <= ld_w_d;
            ld_i_q    <= ld_i_d;
            st_q      <= st_d;
            cfg_reg_q <= cfg_reg_d;
        end
    end

    assign id           = id_q;
    assign broadcast    = bcast_q;
    assign err          = err_q;
    assign cfg          = cfg_q;
    assign load_weight  = ld_w_q;
    assign load_input   = ld_i_q;
    assign store_output = st_q;
    assign cfg_Iext     = cfg_reg_q[0];
    assign cfg_Oext     = cfg_reg_q[1];
    assign cfg_Hext     = cfg_reg_q[2];
    assign cfg_Wext     = cfg_reg_q[3];
    assign cfg_Iori     = cfg_reg_q[4];
    assign cfg_Oori     = cfg_reg_q[5];
    assign cfg_Hori     = cfg_reg_q[6];
    assign cfg_Wori     = cfg_reg_q[7];

endmodule

// File: tb/tb_pe_array_dispatcher.sv
// Self-checking bench for pe_array_dispatcher. Inputs are driven on the
// falling edge and outputs are sampled 1 time unit later, well away from the
// rising edge. Expected stream words go into a scoreboard queue when driven
// and are popped when the DUT presents them.
module tb_pe_array_dispatcher;

    localparam int NPE  = 16;
    localparam int LENW = 16;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [7:0]        cmd_id;
    logic              cmd_bcast;
    logic [LENW-1:0]   cmd_len;
    logic              src_valid;
    logic              src_ready;
    logic [15:0]       src_data;
    logic              snk_valid;
    logic              snk_ready;
    logic [15:0]       snk_data;
    logic [7:0]        id;
    logic              broadcast;
    logic              cfg;
    logic [12:0]       cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext;
    logic [12:0]       cfg_Iori, cfg_Oori, cfg_Hori, cfg_Wori;
    logic              din_valid;
    logic [15:0]       din_data;
    logic              load_weight;
    logic              load_input;
    logic              store_output;
    logic [NPE-1:0]    pe_dout_valid;
    logic [16*NPE-1:0] pe_dout_data;
    logic              dout_ready;
    logic [NPE-1:0]    pe_idle;
    logic              err;

    logic [12:0]       cfg_bus [8];
    logic [15:0]       exp_q [$];
    int                checks = 0;
    int                failures = 0;

    pe_array_dispatcher #(.NPE(NPE), .LENW(LENW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
        .cmd_bcast(cmd_bcast), .cmd_len(cmd_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
        .id(id), .broadcast(broadcast), .cfg(cfg),
        .cfg_Iext(cfg_Iext), .cfg_Oext(cfg_Oext), .cfg_Hext(cfg_Hext), .cfg_Wext(cfg_Wext),
        .cfg_Iori(cfg_Iori), .cfg_Oori(cfg_Oori), .cfg_Hori(cfg_Hori), .cfg_Wori(cfg_Wori),
        .din_valid(din_valid), .din_data(din_data),
        .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
        .pe_dout_valid(pe_dout_valid), .pe_dout_data(pe_dout_data), .dout_ready(dout_ready),
        .pe_idle(pe_idle), .err(err)
    );

    assign cfg_bus[0] = cfg_Iext;
    assign cfg_bus[1] = cfg_Oext;
    assign cfg_bus[2] = cfg_Hext;
    assign cfg_bus[3] = cfg_Wext;
    assign cfg_bus[4] = cfg_Iori;
    assign cfg_bus[5] = cfg_Oori;
    assign cfg_bus[6] = cfg_Hori;
    assign cfg_bus[7] = cfg_Wori;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command for a single cycle and confirm it is accepted.
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] cid,
                            input logic bc, input logic [15:0] len);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_id = cid; cmd_bcast = bc; cmd_len = len;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL cmd_accept got=%b exp=1", cmd_ready); end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Out of reset: idle, nothing asserted, config bus cleared.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({cfg, load_weight, load_input, store_output, din_valid, src_ready, snk_valid, dout_ready, err} !== 9'b0) begin
            failures++; $display("[TB] FAIL reset_outputs got=%b exp=0", {cfg, load_weight, load_input, store_output, din_valid, src_ready, snk_valid, dout_ready, err});
        end
        checks++;
        if (cmd_ready !== 1'b1 || id !== 8'd0 || broadcast !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_idle got ready=%b id=%0d bc=%b exp ready=1 id=0 bc=0", cmd_ready, id, broadcast);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cfg_bus[i] !== 13'd0) begin failures++; $display("[TB] FAIL reset_cfg%0d got=%h exp=0", i, cfg_bus[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // CFG: eight words captured in order, one-cycle cfg strobe, then stable.
    task automatic test_cfg(input logic [7:0] cid, input logic bc, input bit random_words);
        logic [15:0] w;
        logic [15:0] e;
        send_cmd(3'd0, cid, bc, 16'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!random_words)  w = 16'h0010 + 16'(i);
            else if (i == 2)    w = 16'hF234;
            else                w = 16'($urandom);
            src_valid = 1'b1; src_data = w;
            exp_q.push_back({3'b000, w[12:0]});
            #1;
            checks++;
            if (src_ready !== 1'b1 || cfg !== 1'b0) begin failures++; $display("[TB] FAIL cfg_read word%0d got ready=%b cfg=%b exp ready=1 cfg=0", i, src_ready, cfg); end
        end
        @(negedge clk);
        src_valid = 1'b0;
        #1;
        checks++;
        if (cfg !== 1'b1 || id !== cid || broadcast !== bc) begin
            failures++; $display("[TB] FAIL cfg_strobe got cfg=%b id=%0d bc=%b exp cfg=1 id=%0d bc=%b", cfg, id, broadcast, cid, bc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cfg !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL cfg_done got cfg=%b ready=%b exp cfg=0 ready=1", cfg, cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({3'b000, cfg_bus[i]} !== e) begin failures++; $display("[TB] FAIL cfg_field%0d got=%h exp=%h", i, cfg_bus[i], e); end
        end
    endtask

    // LOAD_W with a gapped source: strobe, then exactly len words forwarded.
    task automatic test_load();
        int sent = 0;
        int cyc = 0;
        logic [15:0] e;
        send_cmd(3'd1, 8'd2, 1'b0, 16'd4);
        @(negedge clk);
        #1;
        checks++;
        if (load_weight !== 1'b1 || load_input !== 1'b0 || src_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL load_strobe got lw=%b li=%b rdy=%b exp lw=1 li=0 rdy=0", load_weight, load_input, src_ready);
        end
        while (sent < 4 && cyc < 40) begin
            @(negedge clk);
            src_valid = cyc[0];
            src_data  = 16'($urandom);
            if (src_valid) begin exp_q.push_back(src_data); sent++; end
            #1;
            checks++;
            if (din_valid !== src_valid || src_ready !== 1'b1 || load_weight !== 1'b0) begin
                failures++; $display("[TB] FAIL load_handshake cyc%0d got dv=%b rdy=%b lw=%b exp dv=%b rdy=1 lw=0", cyc, din_valid, src_ready, load_weight, src_valid);
            end
            if (din_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("[TB] FAIL load_extra got=%h exp=none", din_data);
                end else begin
                    e = exp_q.pop_front();
                    if (din_data !== e) begin failures++; $display("[TB] FAIL load_data got=%h exp=%h", din_data, e); end
                end
            end
            cyc++;
        end
        checks++;
        if (sent < 4 || exp_q.size() != 0) begin failures++; $display("[TB] FAIL load_timeout got sent=%0d left=%0d exp sent=4 left=0", sent, exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        src_valid = 1'b1;
        #1;
        checks++;
        if (src_ready !== 1'b0 || din_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL load_exit got rdy=%b dv=%b cmd_rdy=%b exp 0 0 1", src_ready, din_valid, cmd_ready);
        end
        src_valid = 1'b0;
    endtask

    // STORE from PE5 with a stalled sink; other PEs present decoy data.
    task automatic test_store();
        logic [15:0] pe_src [$];
        logic [15:0] e;
        int cyc = 0;
        pe_src = '{16'h00A1, 16'h00A2, 16'h00A3};
        foreach (pe_src[i]) exp_q.push_back(pe_src[i]);
        send_cmd(3'd3, 8'd5, 1'b1, 16'd3);
        while (pe_src.size() > 0 && cyc < 40) begin
            @(negedge clk);
            for (int k = 0; k < NPE; k++) pe_dout_data[16*k +: 16] = 16'hB000 + 16'(k);
            pe_dout_data[16*5 +: 16] = pe_src[0];
            pe_dout_valid = '1;
            snk_ready = (cyc >= 3);
            #1;
            if (cyc == 0) begin
                checks++;
                if (store_output !== 1'b1 || broadcast !== 1'b0 || id !== 8'd5 || snk_valid !== 1'b0 || dout_ready !== 1'b0) begin
                    failures++; $display("[TB] FAIL store_strobe got st=%b bc=%b id=%0d sv=%b dr=%b exp 1 0 5 0 0", store_output, broadcast, id, snk_valid, dout_ready);
                end
            end else begin
                checks++;
                if (dout_ready !== snk_ready || snk_valid !== 1'b1 || store_output !== 1'b0) begin
                    failures++; $display("[TB] FAIL store_handshake cyc%0d got dr=%b sv=%b st=%b exp dr=%b sv=1 st=0", cyc, dout_ready, snk_valid, store_output, snk_ready);
                end
                if (snk_valid === 1'b1 && snk_ready === 1'b1) begin
                    e = exp_q.pop_front();
                    void'(pe_src.pop_front());
                    checks++;
                    if (snk_data !== e) begin failures++; $display("[TB] FAIL store_data got=%h exp=%h", snk_data, e); end
                end
            end
            cyc++;
        end
        checks++;
        if (pe_src.size() != 0) begin failures++; $display("[TB] FAIL store_timeout got left=%0d exp left=0", pe_src.size()); end
        exp_q.delete();
        @(negedge clk);
        snk_ready = 1'b1;
        #1;
        checks++;
        if (snk_valid !== 1'b0 || dout_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL store_exit got sv=%b dr=%b cmd_rdy=%b exp 0 0 1", snk_valid, dout_ready, cmd_ready);
        end
        pe_dout_valid = '0;
        snk_ready = 1'b0;
    endtask

    // WAIT_IDLE: broadcast waits on every PE, unicast only on its own PE.
    task automatic test_wait();
        pe_idle = 16'hFFFE;
        send_cmd(3'd4, 8'd0, 1'b1, 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL wait_hold cyc%0d got=%b exp=0", i, cmd_ready); end
        end
        @(negedge clk);
        pe_idle = 16'hFFFF;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL wait_edge got=%b exp=0", cmd_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL wait_release got=%b exp=1", cmd_ready); end
        pe_idle = 16'h0001;
        send_cmd(3'd4, 8'd0, 1'b0, 16'd0);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL wait_unicast got=%b exp=1", cmd_ready); end
        pe_idle = 16'hFFFF;
    endtask

    // Out-of-range unicast id: consumed, err set, nothing issued.
    task automatic test_err();
        send_cmd(3'd2, 8'd20, 1'b0, 16'd8);
        src_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (err !== 1'b1 || load_input !== 1'b0 || src_ready !== 1'b0 || cmd_ready !== 1'b1) begin
                failures++; $display("[TB] FAIL err_cmd cyc%0d got err=%b li=%b rdy=%b cmd_rdy=%b exp 1 0 0 1", i, err, load_input, src_ready, cmd_ready);
            end
        end
        src_valid = 1'b0;
    endtask

    // Reset in the middle of a LOAD abandons it and clears everything.
    task automatic test_reset_mid();
        send_cmd(3'd2, 8'd1, 1'b0, 16'd10);
        @(negedge clk);
        #1;
        checks++;
        if (load_input !== 1'b1) begin failures++; $display("[TB] FAIL mid_strobe got=%b exp=1", load_input); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            src_valid = 1'b1; src_data = 16'h5500 + 16'(i);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cfg, load_weight, load_input, store_output, din_valid, src_ready, snk_valid, dout_ready, err} !== 9'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL mid_reset got=%b ready=%b exp=0 ready=1", {cfg, load_weight, load_input, store_output, din_valid, src_ready, snk_valid, dout_ready, err}, cmd_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cfg_bus[i] !== 13'd0) begin failures++; $display("[TB] FAIL mid_cfg%0d got=%h exp=0", i, cfg_bus[i]); end
        end
        src_valid = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_id = '0; cmd_bcast = 1'b0; cmd_len = '0;
        src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
        pe_dout_valid = '0; pe_dout_data = '0; pe_idle = '1;
        test_reset();
        test_cfg(8'd3, 1'b0, 1'b0);
        test_cfg(8'd7, 1'b1, 1'b1);
        test_load();
        test_store();
        test_wait();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
